onehot_encoder32x5_seq: RTL and testbench

Sequential 32-to-5 encoder, the inverse of the 5x32 decoder. It accepts a 32-bit request vector over a valid/ready handshake and emits the 5-bit index of every set bit, one index per accepted output beat. It sits downstream of decoded select/request lines and turns them back into binary indices for logging or arbitration.

---
 rtl/onehot_encoder32x5_seq_pkg.sv | 12 +
 rtl/onehot_encoder32x5_seq_pri_enc32.sv | 18 +
 rtl/onehot_encoder32x5_seq.sv | 50 +++++
 tb/tb_onehot_encoder32x5_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/onehot_encoder32x5_seq_pkg.sv
// enc_pkg: shared widths, FSM state type and a popcount helper for the 32-to-5 encoder.
package enc_pkg;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic int onehot_count(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/onehot_encoder32x5_seq_pri_enc32.sv
// pri_enc32: combinational priority encoder (lowest set bit, or highest when MSB_FIRST).
module pri_enc32 import enc_pkg::*; #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);
  // Scan toward the winning end so the last hit is the selected bit.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec[MSB_FIRST ? i : WIDTH-1-i]) idx = IDX_W'(MSB_FIRST ? i : WIDTH-1-i);
  end
  assign any    = |vec;
  assign single = any && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/onehot_encoder32x5_seq.sv
// onehot_encoder32x5_seq: emits the index of every set bit of a captured vector, one per beat.
// Define ENC_MSB_FIRST_EN for descending emission order (highest set bit first).
module onehot_encoder32x5_seq import enc_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_pulse,
  output logic             busy
);
`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  state_t           state, state_nxt;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] idx;
  logic             any, single, take, fire;
  pri_enc32 #(.MSB_FIRST(MSB_FIRST)) u_enc (.vec(pending), .idx(idx), .any(any), .single(single));
  assign take = in_valid && in_ready;
  assign fire = out_valid && out_ready;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? ((take && |in_data) ? EMIT : IDLE)
                                : (((fire && single) || !any) ? IDLE : EMIT);
  always_comb begin
    in_ready  = !rst && en && (state == IDLE);
    out_valid = state == EMIT;
    out_idx   = out_valid ? idx : '0;
    out_last  = out_valid && single;
    busy      = out_valid;
  end
  // Each accepted beat knocks out the bit just reported.
  always_ff @(posedge clk)
    if (rst) begin
      pending    <= '0;
      zero_pulse <= 1'b0;
    end else begin
      zero_pulse <= take && (in_data == '0);
      if (take) pending <= in_data;
      else if (fire) pending <= pending & ~(WIDTH'(1) << idx);
    end
endmodule

// File: tb/tb_onehot_encoder32x5_seq.sv
// tb_onehot_encoder32x5_seq: randomized and directed scoreboard bench for the sequential 32-to-5 encoder.
module tb_onehot_encoder32x5_seq;
  import enc_pkg::*;
`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  typedef struct {int idx; bit last;} beat_t;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_last, zero_pulse, busy;
  logic [4:0]  out_idx;
  beat_t       q[$];
  bit          exp_zp = 1'b0;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  onehot_encoder32x5_seq dut (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .zero_pulse(zero_pulse), .busy(busy));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: one beat per set bit, in the configured order, last flag on the final one.
  function automatic void push_beats(input logic [31:0] v);
    int n, k, i;
    n = onehot_count(v);
    k = 0;
    for (int j = 0; j < 32; j++) begin
      i = MSB_FIRST ? 31 - j : j;
      if (v[i]) begin
        k++;
        q.push_back('{i, k == n});
      end
    end
  endfunction
  always @(negedge clk) begin
    bit exp_valid;
    if (rst) begin
      chk("rst_in_ready", int'(in_ready), 0);
      q.delete();
      exp_zp = 1'b0;
    end else begin
      exp_valid = q.size() != 0;
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_valid));
      chk("zero_pulse", int'(zero_pulse), int'(exp_zp));
      chk("in_ready", int'(in_ready), int'(en && !exp_valid));
      if (exp_valid) begin
        chk("out_idx", int'(out_idx), q[0].idx);
        chk("out_last", int'(out_last), int'(q[0].last));
      end else begin
        chk("idle_idx", int'(out_idx), 0);
        chk("idle_last", int'(out_last), 0);
      end
      exp_zp = 1'b0;
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && en && !exp_valid) begin
        exp_zp = in_data == '0;
        push_beats(in_data);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    int rdy_pat[5] = '{0, 0, 1, 0, 1};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    en = 1'b1;
    send(32'h0000_0001);
    repeat (3) tick();
    send(32'h8000_0011);
    repeat (5) tick();
    send(32'h0000_0000);
    repeat (3) tick();
    send(32'h0000_00C0);
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i][0];
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    send(32'hFFFF_FFFF);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(32'h0000_0005);
    repeat (4) tick();
    en = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0000_0300;
    repeat (3) tick();
    en = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1;
    in_data = 32'h0000_0011;
    repeat (6) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom % 4) != 0;
      in_valid  = ($urandom % 2) != 0;
      case ($urandom % 4)
        0: in_data = 32'h0;
        1: in_data = $urandom & $urandom & $urandom;
        2: in_data = 32'h1 << ($urandom % 32);
        default: in_data = $urandom;
      endcase
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    chk("drain_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
